// File: rtl/mdu_iter_div_pkg.sv
// Shared encodings for the iterative HI/LO divider: FSM states, ready and start levels.
package mdu_iter_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Native register width of the core and the HI/LO pair built from it.
  localparam int REG_W        = 32;
  localparam int DOUBLE_REG_W = 2 * REG_W;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring shift-subtract divide step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when no borrow results.
module mdu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem,
  input  logic              din,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_next,
  output logic              quot_bit
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;

  always_comb begin
    shifted  = (rem << 1) | {{DATA_W{1'b0}}, din};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    // The extra top bit of diff is the borrow: set means the divisor did not fit.
    quot_bit = ~diff[DATA_W+1];
    rem_next = diff[DATA_W+1] ? shifted : diff[DATA_W:0];
  end

endmodule

// File: rtl/mdu_iter_div.sv
// Multi-cycle signed/unsigned divider producing {remainder, quotient} for HI/LO.
// Define MDU_DIV_BYZERO_FLAG_EN to add the registered div_by_zero_o output.
module mdu_iter_div
  import mdu_iter_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
`ifdef MDU_DIV_BYZERO_FLAG_EN
  ,
  output logic                  div_by_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W:0]   rem_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] quot_q;
  logic              signed_q;
  logic              dvd_neg_q;
  logic              dvs_neg_q;

  logic [DATA_W:0]   step_rem;
  logic              step_bit;
  logic              last_step;
  logic [DATA_W-1:0] quot_next;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              enter_end;

  mdu_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem_q),
    .din      (dvd_q[DATA_W-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quot_bit (step_bit)
  );

  always_comb begin
    last_step = (cnt_q == CNT_W'(DATA_W - 1));
    quot_next = (quot_q << 1) | {{(DATA_W-1){1'b0}}, step_bit};
    // Signed results: quotient negative when signs differ, remainder follows the dividend.
    quot_fix  = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? -quot_next : quot_next;
    rem_fix   = (signed_q & dvd_neg_q) ? -step_rem[DATA_W-1:0] : step_rem[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_FREE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    enter_end = 1'b0;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i)
          state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: begin
        state_d   = annul_i ? DIV_FREE : DIV_END;
        enter_end = ~annul_i;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (last_step) begin
          state_d   = DIV_END;
          enter_end = 1'b1;
        end
      end
      DIV_END: begin
        if (annul_i || start_i == DIV_STOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      signed_q  <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      if (state_q == DIV_FREE && state_d == DIV_ON) begin
        cnt_q     <= '0;
        rem_q     <= '0;
        quot_q    <= '0;
        signed_q  <= signed_div_i;
        dvd_neg_q <= opdata1_i[DATA_W-1];
        dvs_neg_q <= opdata2_i[DATA_W-1];
        dvd_q     <= (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        dvs_q     <= (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
      end else if (state_q == DIV_ON && !annul_i) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        rem_q  <= step_rem;
        dvd_q  <= dvd_q << 1;
        quot_q <= quot_next;
      end

      // result_o is only written on entry to END, so an annulled run leaves it untouched.
      if (enter_end)
        result_o <= (state_q == DIV_ON) ? {rem_fix, quot_fix} : '0;

      ready_o <= (state_d == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    end
  end

  assign stall_req_o = ~rst & start_i & ~ready_o & ~annul_i;

`ifdef MDU_DIV_BYZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)
      div_by_zero_o <= 1'b0;
    else if (state_q == DIV_BY_ZERO && enter_end)
      div_by_zero_o <= 1'b1;
    else if (state_q == DIV_END && state_d != DIV_END)
      div_by_zero_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mdu_iter_div.sv
// Directed bench for mdu_iter_div at DATA_W=32 and DATA_W=8 with hand-computed results.
module tb_mdu_iter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sd, start, annul;
  logic [31:0] a, b;
  logic [63:0] res;
  logic        rdy, stall;

  logic        rst8, sd8, start8, annul8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8, stall8;

`ifdef MDU_DIV_BYZERO_FLAG_EN
  logic        dbz, dbz8;
`endif

  mdu_iter_div #(.DATA_W(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sd),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (res),
    .ready_o      (rdy),
    .stall_req_o  (stall)
`ifdef MDU_DIV_BYZERO_FLAG_EN
    ,
    .div_by_zero_o (dbz)
`endif
  );

  mdu_iter_div #(.DATA_W(8)) u_dut8 (
    .clk          (clk),
    .rst          (rst8),
    .signed_div_i (sd8),
    .opdata1_i    (a8),
    .opdata2_i    (b8),
    .start_i      (start8),
    .annul_i      (annul8),
    .result_o     (res8),
    .ready_o      (rdy8),
    .stall_req_o  (stall8)
`ifdef MDU_DIV_BYZERO_FLAG_EN
    ,
    .div_by_zero_o (dbz8)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full handshake at W=32: accept, count edges to ready, check result, drop start.
  task automatic div32(input string tag, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp_res, input int exp_lat);
    int n = 0;
    int stall_bad = 0;
    @(posedge clk); #1;
    sd = s; a = x; b = y; start = 1'b1;
    #1 check($sformatf("%s_stall_idle", tag), stall, 1'b1);
    @(posedge clk); #1;
    while (!rdy && n < 40) begin
      if (!stall) stall_bad++;
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s_latency", tag), n, exp_lat);
    check($sformatf("%s_stall_busy", tag), stall_bad, 0);
    check($sformatf("%s_result", tag), res, exp_res);
    check($sformatf("%s_stall_ready", tag), stall, 1'b0);
`ifdef MDU_DIV_BYZERO_FLAG_EN
    check($sformatf("%s_dbz_flag", tag), dbz, (y == 32'd0));
`endif
    start = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_ready_drop", tag), rdy, 1'b0);
    check($sformatf("%s_result_held", tag), res, exp_res);
  endtask

  task automatic div8(input string tag, input logic [7:0] x, input logic [7:0] y,
                      input logic [15:0] exp_res, input int exp_lat);
    int n = 0;
    @(posedge clk); #1;
    sd8 = 1'b0; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    while (!rdy8 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s_latency", tag), n, exp_lat);
    check($sformatf("%s_result", tag), res8, exp_res);
    start8 = 1'b0;
    @(posedge clk); #1;
    check($sformatf("%s_ready_drop", tag), rdy8, 1'b0);
  endtask

  initial begin
    int rises;
    rst = 1'b1; sd = 1'b0; start = 1'b1; annul = 1'b0; a = '0; b = '0;
    rst8 = 1'b1; sd8 = 1'b0; start8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
    #1 check("rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", res, 64'd0);
    check("rst_ready", rdy, 1'b0);
    start = 1'b0; rst = 1'b0; rst8 = 1'b0;

    div32("u100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 32);
    div32("s_m7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 32);
    div32("s_7_m2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 32);
    div32("byzero",   1'b0, 32'd5,          32'd0,          64'd0,                 1);
    div32("s_minneg", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 32);
    div32("u_minneg", 1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 32);

    // Annul pulsed in the fifth cycle after acceptance of 100 / 7.
    @(posedge clk); #1;
    sd = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    annul = 1'b1;
    #1 check("annul_stall", stall, 1'b0);
    @(posedge clk); #1;
    annul = 1'b0; start = 1'b0;
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rdy) rises++;
    end
    check("annul_no_ready", rises, 0);
    check("annul_result_held", res, 64'h80000000_00000000);
    div32("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32);

    // Narrow instance, then a reset landing mid-operation.
    div8("w8_200_3", 8'd200, 8'd3, 16'h0242, 8);
    @(posedge clk); #1;
    sd8 = 1'b0; a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    check("w8_rst_ready", rdy8, 1'b0);
    check("w8_rst_result", res8, 16'h0000);
    check("w8_rst_stall", stall8, 1'b0);
    rst8 = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    check("w8_rst_idle", rdy8, 1'b0);
    div8("w8_after_rst", 8'd200, 8'd3, 16'h0242, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
